// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package reset_seq_pkg;

  localparam int FAIL_STAGE_W = 3;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_WAIT    = 3'd2,
    ST_RUN     = 3'd3,
    ST_FAULT   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that saturates at zero; expired marks the last cycle of a count.
module cycle_timer #(
  parameter int             W         = 8,
  parameter logic [W-1:0]   RST_VALUE = '0
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= RST_VALUE;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  // High while the count is 1 (or already 0), so the owner acts on the edge that reaches zero.
  assign expired = (count_q <= W'(1));

endmodule

// File: rtl/reset_sequencer.sv
// Releases STAGES reset domains in order, waiting for each stage's ready, with bounded retries.
// state   | meaning
// HOLD    | all domains in reset, idx cleared, delay timer loaded
// RELEASE | counting DELAY before releasing stage idx
// WAIT    | stage idx released, waiting up to TIMEOUT for ready[idx]
// RUN     | all stages released and ready, done high
// FAULT   | retries exhausted, all domains in reset until restart
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int STAGES    = 4,
  parameter int DELAY     = 1000,
  parameter int TIMEOUT   = 100000,
  parameter int MAX_RETRY = 3
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    restart,
  input  logic [STAGES-1:0]       ready,
  output logic [STAGES-1:0]       stage_reset,
  output logic [STAGES-1:0]       stage_resetn,
  output logic                    done,
  output logic                    error,
  output logic [FAIL_STAGE_W-1:0] fail_stage
);

  localparam int MAX_DT = (DELAY > TIMEOUT) ? DELAY : TIMEOUT;
  localparam int TW     = $clog2(MAX_DT) + 1;
  localparam int RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TW-1:0]           DELAY_V     = TW'(DELAY);
  localparam logic [TW-1:0]           TIMEOUT_V   = TW'(TIMEOUT);
  localparam logic [RW-1:0]           MAX_RETRY_V = RW'(MAX_RETRY);
  localparam logic [FAIL_STAGE_W-1:0] LAST_IDX    = FAIL_STAGE_W'(STAGES - 1);

  seq_state_e              state_q, state_d;
  logic [FAIL_STAGE_W-1:0] idx_q, idx_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic [STAGES-1:0]       stage_reset_q, stage_reset_d;
  logic [STAGES-1:0]       stage_resetn_q;
  logic                    done_q, done_d;
  logic                    error_q, error_d;
  logic [FAIL_STAGE_W-1:0] fail_stage_q, fail_stage_d;

  logic                    tmr_load;
  logic [TW-1:0]           tmr_value;
  logic                    tmr_expired;
  logic [7:0]              ready_ext;

  // Zero-extended so idx can index it without a width mismatch for any STAGES.
  assign ready_ext = 8'(ready);

  cycle_timer #(
    .W         (TW),
    .RST_VALUE (DELAY_V)
  ) u_timer (
    .clock      (clock),
    .resetn     (resetn),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expired    (tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    retry_d       = retry_q;
    stage_reset_d = stage_reset_q;
    done_d        = done_q;
    error_d       = error_q;
    fail_stage_d  = fail_stage_q;
    tmr_load      = 1'b0;
    tmr_value     = DELAY_V;

    if (restart) begin
      state_d       = ST_HOLD;
      idx_d         = '0;
      retry_d       = '0;
      error_d       = 1'b0;
      done_d        = 1'b0;
      stage_reset_d = '1;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          stage_reset_d = '1;
          done_d        = 1'b0;
          idx_d         = '0;
          tmr_load      = 1'b1;
          tmr_value     = DELAY_V;
          state_d       = ST_RELEASE;
        end
        ST_RELEASE: begin
          if (tmr_expired) begin
            stage_reset_d = stage_reset_q & ~(STAGES'(1) << idx_q);
            tmr_load      = 1'b1;
            tmr_value     = TIMEOUT_V;
            state_d       = ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A ready seen on the final timeout cycle still counts as success.
          if (ready_ext[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
              retry_d = '0;
            end else begin
              idx_d     = idx_q + FAIL_STAGE_W'(1);
              tmr_load  = 1'b1;
              tmr_value = DELAY_V;
              state_d   = ST_RELEASE;
            end
          end else if (tmr_expired) begin
            fail_stage_d  = idx_q;
            stage_reset_d = '1;
            if (retry_q < MAX_RETRY_V) begin
              retry_d = retry_q + RW'(1);
              state_d = ST_HOLD;
            end else begin
              error_d = 1'b1;
              state_d = ST_FAULT;
            end
          end
        end
        ST_RUN: begin
          done_d  = 1'b1;
          retry_d = '0;
          if (!(&ready)) begin
            done_d        = 1'b0;
            stage_reset_d = '1;
            state_d       = ST_HOLD;
          end
        end
        ST_FAULT: begin
          stage_reset_d = '1;
          error_d       = 1'b1;
          done_d        = 1'b0;
        end
        default: begin
          stage_reset_d = '1;
          done_d        = 1'b0;
          state_d       = ST_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_HOLD;
      idx_q          <= '0;
      retry_q        <= '0;
      stage_reset_q  <= '1;
      stage_resetn_q <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      fail_stage_q   <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      retry_q        <= retry_d;
      stage_reset_q  <= stage_reset_d;
      stage_resetn_q <= ~stage_reset_d;
      done_q         <= done_d;
      error_q        <= error_d;
      fail_stage_q   <= fail_stage_d;
    end
  end

  assign stage_reset  = stage_reset_q;
  assign stage_resetn = stage_resetn_q;
  assign done         = done_q;
  assign error        = error_q;
  assign fail_stage   = fail_stage_q;

endmodule
